// File: rtl/bin2bcd_arbiter.sv
// bin2bcd_arbiter: round-robin sequencer sharing one external bin2bcd core; BIN2BCD_TIMEOUT_EN adds a BUSY timeout
module bin2bcd_arbiter #(
  parameter int NREQ     = 4,
  parameter int DW       = 16,
  parameter int RW       = 33,
  parameter int INIT_CYC = 2,
  parameter int TO_CYC   = 64,
  localparam int IW      = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*DW-1:0] bin_in,
  output logic [NREQ-1:0]   gnt,
  output logic              rsp_valid,
  output logic [IW-1:0]     rsp_id,
  output logic [RW-1:0]     rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              core_init,
  output logic [DW-1:0]     core_A,
  input  logic [RW-1:0]     core_result,
  input  logic              core_done
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_RESP} state_t;
  state_t            r_state, w_next;
  logic [IW-1:0]     r_ptr, r_id, w_win;
  logic [3:0]        r_cnt;
  logic [NREQ-1:0]   r_gnt;
  logic              r_rsp_valid, r_rsp_err, r_busy, r_init;
  logic [IW-1:0]     r_rsp_id;
  logic [RW-1:0]     r_rsp_data;
  logic [DW-1:0]     r_core_a;
  logic              w_found, w_init_last, w_to_hit;
  assign gnt         = r_gnt;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_data    = r_rsp_data;
  assign rsp_err     = r_rsp_err;
  assign busy        = r_busy;
  assign core_init   = r_init;
  assign core_A      = r_core_a;
  assign w_init_last = (r_cnt == 4'(INIT_CYC - 1));
`ifdef BIN2BCD_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYC + 1);
  logic [TW-1:0] r_to;
  // BUSY cycle counter, cleared whenever the FSM is outside BUSY
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_to <= '0;
    else      r_to <= (r_state == S_BUSY) ? r_to + TW'(1) : '0;
  assign w_to_hit = (r_state == S_BUSY) && (r_to == TW'(TO_CYC - 1));
`else
  assign w_to_hit = (TO_CYC < 0);
`endif
  // first requester at or after ptr+1, wrapping
  always_comb begin
    w_win   = r_ptr;
    w_found = 1'b0;
    for (int k = 1; k <= NREQ; k++)
      if (!w_found && req[(int'(r_ptr) + k) % NREQ]) begin
        w_win   = IW'((int'(r_ptr) + k) % NREQ);
        w_found = 1'b1;
      end
  end
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = |req ? S_START : S_IDLE;
      S_START: w_next = w_init_last ? S_BUSY : S_START;
      S_BUSY:  w_next = (core_done || w_to_hit) ? S_RESP : S_BUSY;
      default: w_next = S_IDLE;
    endcase
  end
  // registered datapath and outputs
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_ptr       <= IW'(NREQ - 1);
      r_id        <= '0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_busy      <= 1'b0;
      r_init      <= 1'b0;
      r_core_a    <= '0;
    end else begin
      r_gnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_busy      <= (w_next != S_IDLE);
      case (r_state)
        S_IDLE:
          if (|req) begin
            r_gnt    <= NREQ'(1) << w_win;
            r_core_a <= bin_in[int'(w_win)*DW +: DW];
            r_ptr    <= w_win;
            r_id     <= w_win;
            r_init   <= 1'b1;
            r_cnt    <= '0;
          end
        S_START:
          if (w_init_last) r_init <= 1'b0;
          else             r_cnt  <= r_cnt + 4'd1;
        S_BUSY:
          if (core_done || w_to_hit) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_err   <= !core_done;
            r_rsp_data  <= core_done ? core_result : '0;
          end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_bin2bcd_arbiter.sv
// tb_bin2bcd_arbiter: directed bench for bin2bcd_arbiter with a small bin2bcd core model
module tb_bin2bcd_arbiter;
  logic        clk = 0, rst = 0;
  logic [3:0]  req = '0;
  logic [63:0] bin_in = '0;
  logic [3:0]  gnt;
  logic        rsp_valid, rsp_err, busy, core_init;
  logic [1:0]  rsp_id;
  logic [32:0] rsp_data;
  logic [15:0] core_A;
  logic [32:0] core_result = '0;
  logic        core_done = 0;
  int n_cmp = 0, n_err = 0;
  bit m_en = 1, m_early = 0;
  logic m_prev = 0;
  int m_cnt = -1;
  int lat, seen;
  int exp_id[5];
  logic [32:0] exp_dat[5];
  int exp_g3[4];

  bin2bcd_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .bin_in(bin_in), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .core_init(core_init), .core_A(core_A),
    .core_result(core_result), .core_done(core_done)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] bcd(input logic [15:0] a);
    int v = int'(a);
    logic [32:0] r = '0;
    for (int i = 0; i < 5; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // core model: done pulses 4 cycles after init falls; optional stray done on first init cycle
  always @(posedge clk) begin
    m_prev    <= core_init;
    core_done <= 1'b0;
    if (core_init) begin
      m_cnt       <= -1;
      core_result <= bcd(core_A);
      if (m_early && !m_prev) core_done <= 1'b1;
    end else if (m_prev) m_cnt <= 2;
    else if (m_cnt > 0) m_cnt <= m_cnt - 1;
    else if (m_cnt == 0) begin
      core_done <= m_en;
      m_cnt     <= -1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_gnt(input int lim);
    int i = 0;
    while (gnt == 0 && i < lim) begin @(negedge clk); i++; end
    chk("gnt_seen", {63'd0, |gnt}, 64'd1);
  endtask

  task automatic wait_rsp(input int lim, output int cyc);
    int i = 0;
    while (!rsp_valid && i < lim) begin @(negedge clk); i++; end
    cyc = i;
    chk("rsp_seen", {63'd0, rsp_valid}, 64'd1);
  endtask

  initial begin
    exp_id  = '{0, 1, 2, 3, 0};
    exp_dat = '{33'h1, 33'h2, 33'h3, 33'h4, 33'h1};
    exp_g3  = '{0, 2, 0, 2};
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_init", core_init, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_core_A", core_A, 0);
    chk("rst_rsp_err", rsp_err, 0);
    rst = 1;
    // 1: single conversion from requester 0
    bin_in[15:0] = 16'h7771;
    req = 4'b0001;
    wait_gnt(20);
    chk("t1_gnt", gnt, 4'b0001);
    chk("t1_core_A", core_A, 16'h7771);
    chk("t1_init_c1", core_init, 1);
    chk("t1_busy", busy, 1);
    req = 4'b0000;
    @(negedge clk);
    chk("t1_gnt_pulse", gnt, 0);
    chk("t1_init_c2", core_init, 1);
    @(negedge clk);
    chk("t1_init_fall", core_init, 0);
    wait_rsp(30, lat);
    chk("t1_lat", lat, 5);
    chk("t1_rsp_id", rsp_id, 0);
    chk("t1_rsp_data", rsp_data, 33'h30577);
    chk("t1_rsp_err", rsp_err, 0);
    @(negedge clk);
    chk("t1_rsp_pulse", rsp_valid, 0);
    chk("t1_data_hold", rsp_data, 33'h30577);
    chk("t1_idle", busy, 0);
    // 2: all four requesting from reset
    rst = 0;
    req = 4'b1111;
    bin_in = {16'd4, 16'd3, 16'd2, 16'd1};
    @(negedge clk);
    rst = 1;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(30);
      chk("t2_gnt", gnt, 4'b0001 << exp_id[k]);
      chk("t2_core_A", core_A, exp_dat[k]);
      wait_rsp(40, lat);
      chk("t2_rsp_id", rsp_id, exp_id[k]);
      chk("t2_rsp_data", rsp_data, exp_dat[k]);
      @(negedge clk);
    end
    // 3: requesters 0 and 2 only
    rst = 0;
    req = 4'b0101;
    @(negedge clk);
    rst = 1;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(30);
      chk("t3_gnt", gnt, 4'b0001 << exp_g3[k]);
      wait_rsp(40, lat);
      chk("t3_rsp_id", rsp_id, exp_g3[k]);
      @(negedge clk);
    end
    // 4: stray done during START must be ignored
    rst = 0;
    req = 4'b0000;
    m_early = 1;
    @(negedge clk);
    rst = 1;
    bin_in[15:0] = 16'd9999;
    req = 4'b0001;
    wait_gnt(20);
    req = 4'b0000;
    @(negedge clk);
    chk("t4_no_rsp_start", rsp_valid, 0);
    @(negedge clk);
    chk("t4_no_rsp_busy", rsp_valid, 0);
    wait_rsp(30, lat);
    chk("t4_lat", lat, 5);
    chk("t4_rsp_data", rsp_data, 33'h9999);
    @(negedge clk);
    m_early = 0;
    // 5: asynchronous reset during START and during BUSY
    req = 4'b0001;
    wait_gnt(20);
    req = 4'b0000;
    #2 rst = 0;
    #1;
    chk("t5a_gnt", gnt, 0);
    chk("t5a_init", core_init, 0);
    chk("t5a_busy", busy, 0);
    repeat (10) @(negedge clk);
    rst = 1;
    req = 4'b0001;
    wait_gnt(20);
    req = 4'b0000;
    repeat (3) @(negedge clk);
    chk("t5b_busy_pre", busy, 1);
    #2 rst = 0;
    #1;
    chk("t5b_busy", busy, 0);
    chk("t5b_init", core_init, 0);
    chk("t5b_rsp_valid", rsp_valid, 0);
    repeat (10) @(negedge clk);
    rst = 1;
    req = 4'b1010;
    wait_gnt(20);
    chk("t5_gnt_1010", gnt, 4'b0010);
    req = 4'b0000;
    wait_rsp(30, lat);
    chk("t5_rsp_id", rsp_id, 1);
    @(negedge clk);
    // 6: core never answers; without timeout the block stays busy
    m_en = 0;
    req = 4'b0001;
    wait_gnt(20);
    req = 4'b0000;
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      seen += int'(rsp_valid);
    end
    chk("t6_no_rsp", seen, 0);
    chk("t6_busy", busy, 1);
    chk("t6_rsp_err", rsp_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
